// File: rtl/controle_cancela.sv
// Barrier (cancela) controller FSM driving the motor and the 20 s timer.
// Optional motor watchdog enabled by defining GATE_WATCHDOG_EN.
module controle_cancela
`ifdef GATE_WATCHDOG_EN
#(
    parameter int MOTOR_TIMEOUT = 5000,
    parameter int WD_W          = 16
)
`endif
(
    input  logic clk,
    input  logic rest,
    input  logic acesso_ok,
    input  logic veiculo,
    input  logic fc_aberta,
    input  logic fc_fechada,
    input  logic tempo_20s,
    output logic motor_abrir,
    output logic motor_fechar,
    output logic tempo_on_off,
    output logic tempo_rest,
    output logic cancela_aberta,
    output logic erro
);

    typedef enum logic [2:0] {
        FECHADA,
        ABRINDO,
        ABERTA,
        FECHANDO,
        FALHA
    } state_t;

    state_t state_q, state_d;
    logic   tempo_rest_q, tempo_rest_d;
    logic   motor_abrir_q, motor_fechar_q;
    logic   tempo_on_off_q, cancela_aberta_q;

`ifdef GATE_WATCHDOG_EN
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_exp;
    logic            erro_q;

    assign wd_exp = (wd_q == WD_W'(MOTOR_TIMEOUT - 1));
`endif

    always_comb begin
        state_d      = state_q;
        tempo_rest_d = 1'b0;
        case (state_q)
            FECHADA: begin
                if (acesso_ok) state_d = ABRINDO;
            end
            ABRINDO: begin
                if (fc_aberta) begin
                    state_d      = ABERTA;
                    tempo_rest_d = 1'b1;
                end
`ifdef GATE_WATCHDOG_EN
                else if (wd_exp) state_d = FALHA;
`endif
            end
            ABERTA: begin
                // presence keeps restarting the timer until the zone clears
                if (veiculo || acesso_ok) tempo_rest_d = 1'b1;
                else if (tempo_20s)       state_d = FECHANDO;
            end
            FECHANDO: begin
`ifdef GATE_WATCHDOG_EN
                if (!fc_fechada && wd_exp)     state_d = FALHA;
                else
`endif
                if (veiculo || acesso_ok) state_d = ABRINDO;
                else if (fc_fechada)      state_d = FECHADA;
            end
            FALHA:   state_d = FALHA;
            default: state_d = FECHADA;
        endcase
    end

`ifdef GATE_WATCHDOG_EN
    always_comb begin
        wd_d = '0;
        if ((state_d == ABRINDO || state_d == FECHANDO) && state_d != state_q)
            wd_d = '0;
        else if (state_q == ABRINDO || state_q == FECHANDO)
            wd_d = wd_q + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q          <= FECHADA;
            tempo_rest_q     <= 1'b0;
            motor_abrir_q    <= 1'b0;
            motor_fechar_q   <= 1'b0;
            tempo_on_off_q   <= 1'b0;
            cancela_aberta_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            tempo_rest_q     <= tempo_rest_d;
            motor_abrir_q    <= (state_d == ABRINDO);
            motor_fechar_q   <= (state_d == FECHANDO);
            tempo_on_off_q   <= (state_d == ABERTA);
            cancela_aberta_q <= (state_d == ABERTA);
        end
    end

`ifdef GATE_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rest) begin
            wd_q   <= '0;
            erro_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            erro_q <= (state_d == FALHA);
        end
    end

    assign erro = erro_q;
`else
    assign erro = 1'b0;
`endif

    assign motor_abrir    = motor_abrir_q;
    assign motor_fechar   = motor_fechar_q;
    assign tempo_on_off   = tempo_on_off_q;
    assign tempo_rest     = tempo_rest_q;
    assign cancela_aberta = cancela_aberta_q;

endmodule
